// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
// Holds the ALU op codes, datapath width and scheduler state encoding.
package alu_sched_pkg;

    localparam int ALU_SEL_W = 4;
    localparam int ALU_DW    = 32;

    localparam logic [ALU_SEL_W-1:0] ALU_AND = 4'd0;
    localparam logic [ALU_SEL_W-1:0] ALU_OR  = 4'd1;
    localparam logic [ALU_SEL_W-1:0] ALU_XOR = 4'd2;
    localparam logic [ALU_SEL_W-1:0] ALU_ADD = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    // True for op codes the ALU executes: AND, OR, XOR and ADD.
    function automatic logic sel_is_legal(input logic [ALU_SEL_W-1:0] sel);
        return sel <= ALU_ADD;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, with wrap-around.
// Latency: purely combinational. Backpressure: none; the pointer is held by the parent.
// Grant is one-hot; gnt_idx is its binary index and any_vld flags a valid pick.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any_vld
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_vld && req[(int'(ptr) + k) % NREQ]) begin
                any_vld = 1'b1;
                gnt_idx = IDW'((int'(ptr) + k) % NREQ);
            end
        end
        if (any_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one registered ALU among NREQ requesters, round-robin, one op in flight.
// Latency: accept E0, ALU samples E1, resp_valid from E2; at least 4 cycles per op.
// Backpressure: response held until the owner's resp_ready; accepts only in IDLE.
// Option ALU_RR_SCHEDULER_ILLEGAL_OP_EN adds resp_err and short-circuits sel > ADD.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = ALU_DW,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*DW-1:0]        req_a,
    input  logic [NREQ*DW-1:0]        req_b,
    input  logic [NREQ*ALU_SEL_W-1:0] req_sel,
    output logic [NREQ-1:0]           resp_valid,
    input  logic [NREQ-1:0]           resp_ready,
    output logic [DW-1:0]             resp_data,
`ifdef ALU_RR_SCHEDULER_ILLEGAL_OP_EN
    output logic                      resp_err,
`endif
    output logic [IDW-1:0]            gnt_id,
    output logic                      busy,
    output logic [DW-1:0]             alu_a,
    output logic [DW-1:0]             alu_b,
    output logic [ALU_SEL_W-1:0]      alu_sel,
    input  logic [DW-1:0]             alu_out
);

    state_t                 state;
    logic [IDW-1:0]         ptr;
    logic [NREQ-1:0]        win_gnt;
    logic [IDW-1:0]         win_idx;
    logic                   any_vld;
    logic [DW-1:0]          win_a;
    logic [DW-1:0]          win_b;
    logic [ALU_SEL_W-1:0]   win_sel;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (win_gnt),
        .gnt_idx (win_idx),
        .any_vld (any_vld)
    );

    always_comb begin
        win_a   = req_a[int'(win_idx) * DW +: DW];
        win_b   = req_b[int'(win_idx) * DW +: DW];
        win_sel = req_sel[int'(win_idx) * ALU_SEL_W +: ALU_SEL_W];
    end

    // Reset gates the accept so nothing is taken while rst is held.
    assign req_ready = (state == IDLE && !rst) ? win_gnt : '0;
    assign busy      = (state != IDLE);

    always_comb begin
        resp_valid = '0;
        if (state == RESP) begin
            resp_valid[gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_id    <= '0;
            resp_data <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
`ifdef ALU_RR_SCHEDULER_ILLEGAL_OP_EN
            resp_err  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_vld) begin
                        gnt_id <= win_idx;
`ifdef ALU_RR_SCHEDULER_ILLEGAL_OP_EN
                        // Unsupported ops never reach the ALU; its inputs keep the last legal op.
                        if (!sel_is_legal(win_sel)) begin
                            resp_data <= '0;
                            resp_err  <= 1'b1;
                            state     <= RESP;
                        end else begin
                            alu_a    <= win_a;
                            alu_b    <= win_b;
                            alu_sel  <= win_sel;
                            resp_err <= 1'b0;
                            state    <= ISSUE;
                        end
`else
                        alu_a   <= win_a;
                        alu_b   <= win_b;
                        alu_sel <= win_sel;
                        state   <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    resp_data <= alu_out;
                    state     <= RESP;
                end
                RESP: begin
                    if (resp_ready[gnt_id]) begin
                        ptr   <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler with a behavioural alu32 and a transaction-level model.
// Directed cases cover the basic ops, fairness, backpressure, reset mid-op and illegal sel; a random phase follows.
module tb_alu_rr_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DW-1:0]   req_a;
    logic [NREQ*DW-1:0]   req_b;
    logic [NREQ*4-1:0]    req_sel;
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready;
    logic [DW-1:0]        resp_data;
`ifdef ALU_RR_SCHEDULER_ILLEGAL_OP_EN
    logic                 resp_err;
`endif
    logic [IDW-1:0]       gnt_id;
    logic                 busy;
    logic [DW-1:0]        alu_a;
    logic [DW-1:0]        alu_b;
    logic [3:0]           alu_sel;
    logic [DW-1:0]        alu_out = '0;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
`ifdef ALU_RR_SCHEDULER_ILLEGAL_OP_EN
        .resp_err   (resp_err),
`endif
        .gnt_id     (gnt_id),
        .busy       (busy),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out)
    );

    // alu32: registered output, holds its value on undefined codes
    always @(posedge clk) begin
        case (alu_sel)
            4'd0: alu_out <= alu_a & alu_b;
            4'd1: alu_out <= alu_a | alu_b;
            4'd2: alu_out <= alu_a ^ alu_b;
            4'd3: alu_out <= alu_a + alu_b;
            default: alu_out <= alu_out;
        endcase
    end

    int n_chk  = 0;
    int n_pass = 0;

    // Model: pending requests, round-robin pointer, last ALU result and last ALU sel
    bit             pend [NREQ];
    logic [DW-1:0]  pa   [NREQ];
    logic [DW-1:0]  pb   [NREQ];
    logic [3:0]     ps   [NREQ];
    int             m_ptr;
    logic [DW-1:0]  m_last;
    logic [3:0]     m_sel;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [DW-1:0] ref_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [3:0] sel, input logic [DW-1:0] prev);
        longint unsigned s;
        case (sel)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a ^ b;
            4'd3: begin
                s = (longint'(a) + longint'(b)) % (64'd1 << DW);
                return s[DW-1:0];
            end
            default: return prev;
        endcase
    endfunction

    function automatic int ref_winner();
        for (int k = 0; k < NREQ; k++) begin
            if (pend[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [3:0] rand_sel();
        int v;
        v = $urandom_range(0, 9);
        if (v < 8) return 4'(v % 4);
        return 4'($urandom_range(4, 15));
    endfunction

    task automatic arm(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] s);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
        ps[i]   = s;
    endtask

    task automatic arrive();
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) arm(i, $urandom, $urandom, rand_sel());
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]           = pend[i];
            req_a[i*DW +: DW]      = pa[i];
            req_b[i*DW +: DW]      = pb[i];
            req_sel[i*4 +: 4]      = ps[i];
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_gnt_id", gnt_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_sel", alu_sel, 0);
`ifdef ALU_RR_SCHEDULER_ILLEGAL_OP_EN
        chk("rst_resp_err", resp_err, 0);
`endif
    endtask

    // One full transaction from an IDLE cycle through the response handshake.
    task automatic run_one(input int stall, input bit rnd_arrive,
                           output logic [IDW-1:0] g, output logic [DW-1:0] d);
        int              w;
        int              cyc;
        int              exp_lat;
        bit              illegal;
        logic [NREQ-1:0] oh;
        logic [DW-1:0]   exp_d;
        logic [3:0]      exp_sel;
        g = '0;
        d = '0;
        apply();
        #1;
        w = ref_winner();
        if (w < 0) return;
        oh      = '0;
        oh[w]   = 1'b1;
        chk("req_ready_win", req_ready, oh);
        chk("busy_idle", busy, 0);
        illegal = (ps[w] > 4'd3);
`ifdef ALU_RR_SCHEDULER_ILLEGAL_OP_EN
        exp_d   = illegal ? '0 : ref_op(pa[w], pb[w], ps[w], m_last);
        exp_sel = illegal ? m_sel : ps[w];
        exp_lat = illegal ? 0 : 2;
`else
        exp_d   = ref_op(pa[w], pb[w], ps[w], m_last);
        exp_sel = ps[w];
        exp_lat = 2;
`endif
        if (!illegal) m_last = exp_d;
        m_sel = exp_sel;

        @(posedge clk);
        #1;
        pend[w] = 1'b0;
        if (rnd_arrive) arrive();
        apply();
        #1;
        chk("busy_after_accept", busy, 1);
        chk("gnt_id", gnt_id, w);
        chk("alu_sel", alu_sel, exp_sel);
        chk("req_ready_busy", req_ready, 0);

        cyc = 0;
        while (resp_valid == '0 && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", cyc, exp_lat);
        chk("resp_valid", resp_valid, oh);
        chk("resp_data", resp_data, exp_d);
`ifdef ALU_RR_SCHEDULER_ILLEGAL_OP_EN
        chk("resp_err", resp_err, illegal);
`endif
        g = gnt_id;
        d = resp_data;

        for (int s = 0; s < stall; s++) begin
            resp_ready = NREQ'($urandom) & ~oh;
            @(posedge clk);
            #1;
            chk("stall_valid", resp_valid, oh);
            chk("stall_data", resp_data, exp_d);
            chk("stall_req_ready", req_ready, 0);
        end
        resp_ready = oh | NREQ'($urandom);
        @(posedge clk);
        #1;
        resp_ready = '0;
        chk("done_busy", busy, 0);
        chk("done_resp_valid", resp_valid, 0);
        m_ptr = (w + 1) % NREQ;
    endtask

    logic [IDW-1:0] g;
    logic [DW-1:0]  d;
    logic [DW-1:0]  fa [NREQ];
    logic [DW-1:0]  fb [NREQ];
    logic [3:0]     fs [NREQ];
    logic [DW-1:0]  prev_last;
    int             start;

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_sel    = '0;
        resp_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; ps[i] = '0;
        end
        m_ptr  = 0;
        m_last = '0;
        m_sel  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single request: 0xF + 0xF0
        arm(0, 32'h0000_000F, 32'h0000_00F0, 4'd3);
        run_one(0, 0, g, d);
        chk("single_data", d, 32'h0000_00FF);

        // fairness: everyone valid continuously
        fa[0] = 32'h1234_5678; fb[0] = 32'h0F0F_0F0F; fs[0] = 4'd0;
        fa[1] = 32'hA000_0000; fb[1] = 32'h0000_000B; fs[1] = 4'd1;
        fa[2] = 32'hFFFF_0000; fb[2] = 32'h0F0F_0F0F; fs[2] = 4'd2;
        fa[3] = 32'h7FFF_FFFF; fb[3] = 32'h0000_0001; fs[3] = 4'd3;
        for (int i = 0; i < NREQ; i++) arm(i, fa[i], fb[i], fs[i]);
        start = m_ptr;
        for (int k = 0; k < 8; k++) begin
            run_one(0, 0, g, d);
            chk("fair_order", g, (start + k) % NREQ);
            if (g == 2) chk("fair_xor", d, 32'hF0F0_0F0F);
            if (g == 3) chk("fair_add", d, 32'h8000_0000);
            arm(int'(g), fa[g], fb[g], fs[g]);
        end
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;

        // backpressure on requester 1
        arm(1, 32'h0000_1000, 32'h0000_0234, 4'd1);
        run_one(5, 1, g, d);
        chk("bp_data", d, 32'h0000_1234);
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;

        // wrap-around add, then AND
        arm(3, 32'hFFFF_FFFF, 32'h0000_0001, 4'd3);
        run_one(0, 0, g, d);
        chk("wrap_add", d, 32'h0000_0000);
        arm(0, 32'hAAAA_AAAA, 32'hFFFF_0000, 4'd0);
        run_one(1, 0, g, d);
        chk("and_data", d, 32'hAAAA_0000);

        // illegal op code
        prev_last = m_last;
        arm(2, 32'h1357_9BDF, 32'h2468_ACE0, 4'b0111);
        run_one(0, 0, g, d);
`ifdef ALU_RR_SCHEDULER_ILLEGAL_OP_EN
        chk("illegal_data", d, 32'h0);
`else
        chk("illegal_data", d, prev_last);
`endif

        // reset during CAPTURE; ptr is 3 beforehand so req3 would otherwise win
        arm(2, 32'h1, 32'h2, 4'd3);
        run_one(0, 0, g, d);
        arm(1, 32'h5, 32'h3, 4'd3);
        apply();
        #1;
        @(posedge clk);
        #1;
        pend[1] = 1'b0;
        apply();
        @(posedge clk);
        #1;
        chk("capture_busy", busy, 1);
        rst = 1'b1;
        arm(0, 32'h0000_00FF, 32'h0000_0F00, 4'd1);
        arm(3, 32'h0000_0001, 32'h0000_0001, 4'd3);
        apply();
        #1;
        check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        pend[0] = 1'b0;
        pend[3] = 1'b0;
        apply();
        rst    = 1'b0;
        m_ptr  = 0;
        m_last = '0;
        m_sel  = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_resp", resp_valid, 0);
        end
        arm(0, 32'h0000_00FF, 32'h0000_0F00, 4'd1);
        arm(3, 32'h0000_0001, 32'h0000_0001, 4'd3);
        run_one(0, 0, g, d);
        chk("post_rst_gnt", g, 0);
        chk("post_rst_data", d, 32'h0000_0FFF);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            arrive();
            if (!(pend[0] || pend[1] || pend[2] || pend[3]))
                arm($urandom_range(0, NREQ - 1), $urandom, $urandom, rand_sel());
            run_one($urandom_range(0, 3), 1, g, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
